// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg -- shared definitions for the SNN Wishbone initiator.
//
// Contents:
//   snn_state_e       FSM state encoding (IDLE, WR_SPK, CALC, RD_SPK, GAP)
//   SPIKE_WORDS       number of 32-bit words in a 256-bit spike vector
//   DEF_*             default base addresses of the per-core windows
// -----------------------------------------------------------------------------
package snn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_SPK = 3'd1,
    ST_CALC   = 3'd2,
    ST_RD_SPK = 3'd3,
    ST_GAP    = 3'd4
  } snn_state_e;

  localparam int SPIKE_WORDS = 8;

  localparam logic [31:0] DEF_IMEM_BASE_0 = 32'h8000_0000;
  localparam logic [31:0] DEF_IMEM_BASE_1 = 32'h8001_0000;
  localparam logic [31:0] DEF_CALC_BASE   = 32'h8003_0000;
  localparam logic [31:0] DEF_OMEM_BASE_0 = 32'h8004_0000;
  localparam logic [31:0] DEF_OMEM_BASE_1 = 32'h8005_0000;

endpackage

// File: rtl/snn_wb_initiator.sv
// -----------------------------------------------------------------------------
// snn_wb_initiator -- Wishbone classic initiator that runs one SNN timestep on
// one of two cores: write 8 input-spike words, write the calc trigger, then
// read back 8 output-spike words.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, asynchronous active-high reset
//   start_i                request one timestep (accepted only when idle)
//   core_sel_i             target core (0/1), captured at acceptance
//   spike_in_i[255:0]      axon spikes, captured at acceptance
//   busy_o                 transaction active (through the done/err cycle)
//   done_o                 one-cycle pulse after the last read beat
//   err_o                  one-cycle pulse when a beat times out
//   spike_out_o[255:0]     neuron spikes collected by the read beats
//   wbm_*                  Wishbone classic initiator port, all outputs registered
//
// Handshake: a beat is offered while cyc=stb=1 and completes at the clock
// edge where ack is sampled high together with stb; adr/dat/we/sel are frozen
// until then. cyc/stb drop in the following cycle, which is the GAP cycle
// separating beats. An ack seen while stb=0 has no effect.
//
// Configuration macro: SNN_WB_INIT_TIMEOUT_EN
//   defined   -- each beat has a wait counter; after TIMEOUT_CYCLES cycles
//                without ack the transaction is aborted with an err_o pulse
//   undefined -- beats wait for ack indefinitely, err_o is constant 0
//
// The FSM state is r_state (snn_state_e); r_phase holds the phase the next
// beat issued from GAP belongs to.
// -----------------------------------------------------------------------------
module snn_wb_initiator
  import snn_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE_0    = DEF_IMEM_BASE_0,
  parameter logic [31:0] IMEM_BASE_1    = DEF_IMEM_BASE_1,
  parameter logic [31:0] CALC_BASE      = DEF_CALC_BASE,
  parameter logic [31:0] OMEM_BASE_0    = DEF_OMEM_BASE_0,
  parameter logic [31:0] OMEM_BASE_1    = DEF_OMEM_BASE_1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         start_i,
  input  logic         core_sel_i,
  input  logic [255:0] spike_in_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [255:0] spike_out_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic         wbm_ack_i,
  input  logic [31:0]  wbm_dat_i
);

  // A zero timeout would abort every beat before the target could answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("snn_wb_initiator: TIMEOUT_CYCLES must be at least 1");
  end

  snn_state_e   r_state;
  snn_state_e   r_phase;
  logic [2:0]   r_cnt;
  logic         r_core;
  logic [255:0] r_spike_in;
  logic [255:0] r_spike_out;
  logic         r_busy;
  logic         r_done;
  logic         r_cyc;
  logic         r_stb;
  logic         r_we;
  logic [3:0]   r_sel;
  logic [31:0]  r_adr;
  logic [31:0]  r_dat;

`ifdef SNN_WB_INIT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic            r_err;
  logic [TO_W-1:0] r_wait;
`endif

  logic        w_ack;
  logic        w_last_word;
  logic        w_beat_we;
  logic [31:0] w_beat_adr;
  logic [31:0] w_beat_dat;
  logic [31:0] w_word_off;

  // Only an ack that meets an active strobe completes a beat.
  assign w_ack       = wbm_ack_i & r_stb;
  assign w_last_word = (r_cnt == 3'(SPIKE_WORDS - 1));
  assign w_word_off  = {27'd0, r_cnt, 2'b00};

  // Request fields of the next beat, loaded into the wbm_* registers in GAP.
  always_comb begin
    w_beat_we  = 1'b0;
    w_beat_adr = 32'd0;
    w_beat_dat = 32'd0;
    unique case (r_phase)
      ST_WR_SPK: begin
        w_beat_we  = 1'b1;
        w_beat_adr = (r_core ? IMEM_BASE_1 : IMEM_BASE_0) + w_word_off;
        w_beat_dat = r_spike_in[{r_cnt, 5'd0} +: 32];
      end
      ST_CALC: begin
        w_beat_we  = 1'b1;
        w_beat_adr = CALC_BASE + {29'd0, r_core, 2'b00};
        w_beat_dat = 32'h0000_0001;
      end
      ST_RD_SPK: begin
        w_beat_adr = (r_core ? OMEM_BASE_1 : OMEM_BASE_0) + w_word_off;
      end
      default: begin
        w_beat_we  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_phase     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_core      <= 1'b0;
      r_spike_in  <= '0;
      r_spike_out <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_adr       <= 32'd0;
      r_dat       <= 32'd0;
`ifdef SNN_WB_INIT_TIMEOUT_EN
      r_err       <= 1'b0;
      r_wait      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SNN_WB_INIT_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          // r_busy is still high in the done/err cycle, so a start seen
          // there is ignored and busy falls one cycle later.
          if (start_i && !r_busy) begin
            r_busy     <= 1'b1;
            r_core     <= core_sel_i;
            r_spike_in <= spike_in_i;
            r_cnt      <= 3'd0;
            r_phase    <= ST_WR_SPK;
            r_state    <= ST_GAP;
          end else begin
            r_busy <= 1'b0;
          end
        end

        ST_GAP: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_we    <= w_beat_we;
          r_sel   <= 4'hF;
          r_adr   <= w_beat_adr;
          r_dat   <= w_beat_dat;
          r_state <= r_phase;
`ifdef SNN_WB_INIT_TIMEOUT_EN
          r_wait  <= '0;
`endif
        end

        ST_WR_SPK, ST_CALC, ST_RD_SPK: begin
          if (w_ack) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_state <= ST_GAP;
            if (r_state == ST_WR_SPK) begin
              // The 3-bit counter wraps 7->0 on the way into CALC.
              r_cnt <= r_cnt + 3'd1;
              if (w_last_word) r_phase <= ST_CALC;
            end else if (r_state == ST_CALC) begin
              r_phase <= ST_RD_SPK;
            end else begin
              r_spike_out[{r_cnt, 5'd0} +: 32] <= wbm_dat_i;
              r_cnt <= r_cnt + 3'd1;
              if (w_last_word) begin
                r_state <= ST_IDLE;
                r_phase <= ST_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
`ifdef SNN_WB_INIT_TIMEOUT_EN
          else if (r_wait == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the timestep; words already read stay in spike_out.
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_cnt   <= 3'd0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
            r_phase <= ST_IDLE;
          end else begin
            r_wait <= r_wait + TO_W'(1);
          end
`endif
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign spike_out_o = r_spike_out;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_stb;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;

`ifdef SNN_WB_INIT_TIMEOUT_EN
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_snn_wb_initiator.sv
// -----------------------------------------------------------------------------
// tb_snn_wb_initiator -- self-checking bench for snn_wb_initiator.
// Clock/reset block, a behavioural Wishbone target with programmable wait
// states, a negedge bus monitor feeding a scoreboard (exp_q), table-driven
// timesteps and hand-written sequences for reset, spurious ack and timeout.
// -----------------------------------------------------------------------------
module tb_snn_wb_initiator;

  localparam int TO_CYC = 8;
  localparam logic [31:0] NO_ADR = 32'hFFFF_FFF0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_i = 1'b0;
  logic         core_sel_i = 1'b0;
  logic [255:0] spike_in_i = '0;
  logic         busy_o, done_o, err_o;
  logic [255:0] spike_out_o;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat_o, dat_i;
  logic         ack_i;

  snn_wb_initiator #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .start_i(start_i), .core_sel_i(core_sel_i), .spike_in_i(spike_in_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .spike_out_o(spike_out_o),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack_i), .wbm_dat_i(dat_i)
  );

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_fail = 0;
  logic [64:0] exp_q[$];   // {we, adr, dat}; dat ignored for reads

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural target ----------------
  logic [31:0] wait_adr  = NO_ADR;
  int          wait_n    = 0;
  logic [31:0] noack_adr = NO_ADR;
  logic [31:0] rd_base   = 32'd0;
  logic        spur_ack  = 1'b0;
  logic        r_ack;
  int          r_wcnt;

  assign ack_i = r_ack | spur_ack;
  assign dat_i = rd_base + {29'd0, adr[4:2]};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack  <= 1'b0;
      r_wcnt <= 0;
    end else begin
      r_ack <= 1'b0;
      if (cyc && stb && !r_ack && adr != noack_adr) begin
        if (adr == wait_adr && r_wcnt < wait_n) r_wcnt <= r_wcnt + 1;
        else begin
          r_ack  <= 1'b1;
          r_wcnt <= 0;
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic [64:0] held, cur, e, mask;
  bit in_beat = 0;
  int beat_cnt = 0, done_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (rst) in_beat = 0;
    else begin
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (cyc || stb) check("cyc_eq_stb", 256'(cyc), 256'(stb));
      if (stb) begin
        cur = {we, adr, dat_o};
        if (in_beat) check("beat_stable", 256'(cur), 256'(held));
        else begin
          in_beat = 1;
          held = cur;
          check("sel", 256'(sel), 256'(4'hF));
        end
        if (ack_i) begin
          in_beat = 0;
          beat_cnt++;
          if (exp_q.size() == 0) check("unexpected_beat", 256'(cur), 256'(0));
          else begin
            e = exp_q.pop_front();
            mask = e[64] ? {65{1'b1}} : {1'b1, 32'hFFFF_FFFF, 32'h0};
            check("beat", 256'(cur & mask), 256'(e & mask));
          end
        end
      end else in_beat = 0;
    end
  end

  // ---------------- model / driver tasks ----------------
  task automatic push_expected(input logic core, input logic [255:0] spk);
    logic [31:0] ib, ob;
    ib = core ? 32'h8001_0000 : 32'h8000_0000;
    ob = core ? 32'h8005_0000 : 32'h8004_0000;
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, ib + 32'(4 * k), spk[32 * k +: 32]});
    exp_q.push_back({1'b1, 32'h8003_0000 + (core ? 32'd4 : 32'd0), 32'h1});
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, ob + 32'(4 * k), 32'h0});
  endtask

  typedef struct {
    logic         core;
    logic [255:0] spike;
    logic [31:0]  rd_base;
    logic [31:0]  wait_adr;
    int           wait_n;
    int           restart_at;
    int           exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int cyc_n, d0, b0;
    logic [255:0] exp_out;
    for (int k = 0; k < 8; k++) exp_out[32 * k +: 32] = v.rd_base + 32'(k);
    wait_adr = v.wait_adr;
    wait_n   = v.wait_n;
    rd_base  = v.rd_base;
    d0 = done_cnt;
    b0 = beat_cnt;
    @(negedge clk);
    core_sel_i = v.core;
    spike_in_i = v.spike;
    start_i    = 1'b1;
    push_expected(v.core, v.spike);
    @(negedge clk);
    start_i    = 1'b0;
    core_sel_i = ~v.core;      // later changes must not reach the bus
    spike_in_i = ~v.spike;
    check("busy_after_accept", 256'(busy_o), 256'(1));
    cyc_n = 0;
    while (done_o !== 1'b1 && cyc_n < 300) begin
      @(negedge clk);
      cyc_n++;
      start_i = (cyc_n == v.restart_at);
    end
    start_i = 1'b0;
    check("done_latency", 256'(cyc_n), 256'(v.exp_lat));
    check("busy_at_done", 256'(busy_o), 256'(1));
    check("err_at_done", 256'(err_o), 256'(0));
    check("spike_out", spike_out_o, exp_out);
    @(negedge clk);
    check("done_pulse_end", 256'({done_o, busy_o}), 256'(0));
    repeat (4) @(negedge clk);
    check("idle_cyc", 256'(cyc), 256'(0));
    check("done_count", 256'(done_cnt - d0), 256'(1));
    check("beat_count", 256'(beat_cnt - b0), 256'(17));
    check("queue_empty", 256'(exp_q.size()), 256'(0));
    exp_q.delete();
    wait_adr = NO_ADR;
    wait_n   = 0;
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[5];
  logic [255:0] rnd, prev_out;
  int n, d0, e0, b0;

  initial begin
    for (int i = 0; i < 5; i++) begin
      for (int w = 0; w < 8; w++) rnd[32 * w +: 32] = $urandom();
      vecs[i] = '{core: 1'b0, spike: rnd, rd_base: 32'h0, wait_adr: NO_ADR,
                  wait_n: 0, restart_at: -1, exp_lat: 51};
    end
    vecs[0].spike = 256'h1;
    vecs[1].core = 1'b1; vecs[1].rd_base = 32'hA5A5_0000;
    vecs[2].rd_base = 32'h1234_0000; vecs[2].wait_adr = 32'h8000_0010;
    vecs[2].wait_n = 3; vecs[2].exp_lat = 54;
    vecs[3].core = 1'b1; vecs[3].rd_base = 32'hDEAD_0000; vecs[3].restart_at = 5;
    vecs[4].core = 1'b1; vecs[4].spike = {256{1'b1}}; vecs[4].rd_base = 32'hFFFF_FFF8;
    vecs[4].wait_adr = 32'h8003_0004; vecs[4].wait_n = 2; vecs[4].exp_lat = 53;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cyc", 256'(cyc), 256'(0));
    check("rst_stb", 256'(stb), 256'(0));
    check("rst_we", 256'(we), 256'(0));
    check("rst_sel", 256'(sel), 256'(0));
    check("rst_adr", 256'(adr), 256'(0));
    check("rst_dat", 256'(dat_o), 256'(0));
    check("rst_busy", 256'(busy_o), 256'(0));
    check("rst_done", 256'(done_o), 256'(0));
    check("rst_err", 256'(err_o), 256'(0));
    check("rst_spike_out", spike_out_o, 256'(0));
    rst = 1'b0;

    // ack without strobe while idle
    repeat (2) @(negedge clk);
    spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    spur_ack = 1'b0;
    check("spur_ack_cyc", 256'(cyc), 256'(0));
    check("spur_ack_busy", 256'(busy_o), 256'(0));
    check("spur_ack_beats", 256'(beat_cnt), 256'(0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset during read beat 3
    rd_base = 32'h5A5A_0000;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    core_sel_i = 1'b0; spike_in_i = vecs[2].spike; start_i = 1'b1;
    push_expected(1'b0, vecs[2].spike);
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(stb && adr == 32'h8004_000C) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_rd_beat3", 256'(stb && adr == 32'h8004_000C), 256'(1));
    check("partial_before_rst", spike_out_o[95:0], {32'h5A5A_0002, 32'h5A5A_0001, 32'h5A5A_0000});
    #1 rst = 1'b1;
    #1;
    check("rst_mid_cyc", 256'({cyc, stb}), 256'(0));
    check("rst_mid_spike_out", spike_out_o, 256'(0));
    check("rst_mid_busy", 256'(busy_o), 256'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", 256'(done_cnt - d0), 256'(0));
    check("rst_mid_no_err", 256'(err_cnt - e0), 256'(0));
    run_vec(vecs[0]);

`ifdef SNN_WB_INIT_TIMEOUT_EN
    // calc beat never acknowledged
    noack_adr = 32'h8003_0000;
    prev_out = spike_out_o;
    d0 = done_cnt; e0 = err_cnt; b0 = beat_cnt;
    @(negedge clk);
    core_sel_i = 1'b0; spike_in_i = vecs[1].spike; start_i = 1'b1;
    push_expected(1'b0, vecs[1].spike);
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(stb && adr == 32'h8003_0000) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_calc", 256'(stb && adr == 32'h8003_0000), 256'(1));
    n = 0;
    while (stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_stb_cycles", 256'(n), 256'(TO_CYC));
    check("timeout_err", 256'(err_o), 256'(1));
    check("timeout_busy_err_cycle", 256'(busy_o), 256'(1));
    @(negedge clk);
    check("timeout_err_end", 256'({err_o, busy_o}), 256'(0));
    repeat (3) @(negedge clk);
    check("timeout_no_done", 256'(done_cnt - d0), 256'(0));
    check("timeout_err_count", 256'(err_cnt - e0), 256'(1));
    check("timeout_beats", 256'(beat_cnt - b0), 256'(8));
    check("timeout_spike_out", spike_out_o, prev_out);
    exp_q.delete();
    noack_adr = NO_ADR;
    run_vec(vecs[1]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
